// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC unit: select encoding and default
// architectural vectors.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_HOLD,
        SEL_JR,
        SEL_RET,
        SEL_J,
        SEL_BR,
        SEL_SEQ
    } pc_sel_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry; a pop on an empty stack is ignored.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [CW-1:0]   count;
    logic            pop_eff;
    logic [PW-1:0]   wr_ptr;

    assign empty    = (count == '0);
    assign pop_eff  = pop && !empty;
    assign top_data = mem[top];
    // A simultaneous pop and push replaces the current top in place.
    assign wr_ptr   = pop_eff ? top : top + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top   <= '0;
            count <= '0;
        end else if (push && !pop_eff) begin
            top <= top + PW'(1);
            if (count != CW'(RAS_DEPTH))
                count <= count + CW'(1);
        end else if (pop_eff && !push) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with fixed-priority next-PC selection,
// exception vectoring, jr alignment check and return-address stack.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEFAULT_EXC_VECTOR),
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            exception,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-7:0] jump_index,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] reg_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            ras_empty,
    output logic            addr_err
);

    pc_sel_t         sel;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;

    assign pc_plus4 = pc + XLEN'(4);
    assign ras_push = call && !stall && !exception;
    assign ras_pop  = ret  && !stall && !exception;

    always_comb begin
        sel = SEL_SEQ;
        if (exception)               sel = SEL_EXC;
        else if (stall)              sel = SEL_HOLD;
        else if (jump_reg)           sel = SEL_JR;
        else if (ret && !ras_empty)  sel = SEL_RET;
        else if (jump)               sel = SEL_J;
        else if (branch)             sel = SEL_BR;
    end

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_EXC:  pc_next = EXC_VECTOR;
            SEL_HOLD: pc_next = pc;
            SEL_JR:   pc_next = reg_target & ~XLEN'(3);
            SEL_RET:  pc_next = ras_top;
            SEL_J:    pc_next = {pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00};
            SEL_BR:   pc_next = branch_target & ~XLEN'(3);
            default:  pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            addr_err <= 1'b0;
        end else begin
            pc       <= pc_next;
            addr_err <= (sel == SEL_JR) && (reg_target[1:0] != 2'b00);
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top_data  (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the combinational next-PC selector used by the MIPS mono-cycle datapath.
- Owns the architectural PC register and selects the next PC by fixed priority: reset, exception, stall, jump-register, return, jump, branch, PC+4.
- Adds stall hold, an exception vector, a jr alignment check, and an internal return-address stack (RAS) for call/return.
- Sits between the control unit and instruction memory; drives the fetch address directly.

Parameters:
- XLEN, 32, datapath and PC width; minimum 8.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC value loaded when an exception is taken.
- RAS_DEPTH, 4, number of RAS entries; a power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- exception  in  1  take EXC_VECTOR next.
- branch  in  1  conditional branch taken (condition already resolved).
- branch_target  in  XLEN  PC+4 + (sign-extended immediate << 2), computed externally.
- jump  in  1  J/JAL.
- jump_index  in  XLEN-6  instruction index field.
- jump_reg  in  1  JR/JALR.
- reg_target  in  XLEN  register-file value for jr.
- call  in  1  push PC+4 onto the RAS (JAL/JALR).
- ret  in  1  pop the RAS and use its top entry as the target.
- pc  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc + 4, combinational.
- ras_empty  out  1  RAS holds no valid entry.
- addr_err  out  1  registered one-cycle pulse when jr is taken with reg_target[1:0] != 0.

Behaviour:
- Reset (asynchronous, active-high): pc = RESET_PC, RAS count = 0, top-of-stack pointer = 0, addr_err = 0, ras_empty = 1. RAS entry contents are don't-care.
- Next-PC is selected combinationally and registered with one-cycle latency. Priority, highest first:
  1. exception -> EXC_VECTOR. Also takes effect while stall is high.
  2. stall -> hold pc. No RAS push or pop.
  3. jump_reg -> {reg_target[XLEN-1:2], 2'b00}.
  4. ret with RAS non-empty -> top-of-stack entry. ret with the RAS empty falls through to the next rule.
  5. jump -> {pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00}.
  6. branch -> branch_target with bits [1:0] forced to 0.
  7. otherwise -> pc_plus4.
- pc_plus4 wraps modulo 2^XLEN. pc_plus4 at 0xFFFF_FFFC is 0x0000_0000.
- addr_err:
  - Asserts for exactly one cycle after an edge where jump_reg is selected (no exception, no stall) and reg_target[1:0] != 0.
  - The PC is still loaded with the forced-aligned value.
- RAS push: on an edge with call=1, stall=0, exception=0, write pc_plus4 at top+1; top increments and count saturates at RAS_DEPTH.
- RAS overflow: a push when full overwrites the oldest entry (circular buffer); count stays at RAS_DEPTH.
- RAS pop: on an edge with ret=1, stall=0, exception=0 and count > 0, top decrements and count decrements.
- Empty pop: no pointer change and no error.
- call and ret in the same cycle: the pop reads the old top, then the push writes into the same slot. Net effect: top and count unchanged, top entry replaced by pc_plus4.
- Exception suppresses RAS updates; the RAS contents are kept.
- ras_empty = (count == 0).
- Reset asserted mid-operation overrides everything immediately.

Decomposition:
- Shared package pc_pkg:
  - Next-PC select encoding: SEL_EXC, SEL_HOLD, SEL_JR, SEL_RET, SEL_J, SEL_BR, SEL_SEQ.
  - Default RESET_PC and EXC_VECTOR constants.
- One sub-module: ras_stack (parameters XLEN, RAS_DEPTH; ports push, pop, push_data, top_data, empty), instantiated once.
- The priority select and PC register stay in pc_next_unit.

Test Plan:
- Reset check, then free run: reset released with no controls asserted -> pc = 0x0, then 0x4, 0x8, 0xC on successive edges.
- Priority at one edge:
  - pc = 0x10, branch=1 with branch_target = 0x1000, jump=1 with jump_index = 0x800 -> pc = 0x2000 (jump wins).
  - The same inputs plus exception -> pc = 0x180.
- Stall: at pc = 0x40, stall=1 for 3 cycles with call=1 -> pc stays 0x40 and ras_empty stays 1. Then exception with stall=1 -> pc = 0x180.
- Call/return:
  - At pc = 0x100, jump to 0x400 with call=1 -> RAS top = 0x104.
  - At pc = 0x400, ret=1 -> pc = 0x104 and ras_empty = 1.
  - A further ret=1 with the RAS empty at pc = 0x104 -> pc = 0x108.
- RAS overflow (RAS_DEPTH=4): 5 calls pushing 0x14, 0x24, 0x34, 0x44, 0x54 -> 4 rets return 0x54, 0x44, 0x34, 0x24, then ras_empty = 1.
- jr alignment, then reset mid-run:
  - jump_reg=1 with reg_target = 0x203 -> pc = 0x200 and addr_err high for exactly one cycle.
  - Assert reset between clock edges -> pc = 0x0 immediately and ras_empty = 1.
